imm_extend_ctrl: RTL

Decode-stage immediate controller for the DLX pipeline. It accepts fetched instruction words over a valid/ready handshake and classifies each opcode into an extension mode. It produces the 32-bit immediate operand through a two-stage registered pipeline with backpressure and flush, and sits between the IF/ID register and the ID/EX operand muxes.

---
 rtl/imm_extend_ctrl_if.sv | 25 ++
 rtl/imm_extend_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/imm_extend_ctrl_if.sv
// Handshake bundle between the IF/ID register, the immediate controller and the ID/EX operand muxes.
interface imm_extend_ctrl_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] in_instr;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_imm;
  logic [1:0]             out_mode;
  logic                   out_is_jump;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_mode, out_is_jump
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_imm, out_mode, out_is_jump
  );
endinterface

// File: rtl/imm_extend_ctrl.sv
// DLX decode-stage immediate extender: two-stage valid/ready pipeline with flush.
// Optional negative-immediate statistics counter enabled by defining IMM_STATS_EN.
module imm_extend_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_extend_ctrl_if.slave     bus
`ifdef IMM_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [15:0]          stat_neg_cnt
`endif
);

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_SEXT16,
    CLS_ZEXT16,
    CLS_LHI,
    CLS_J26
  } cls_e;

  typedef enum logic [1:0] {
    MODE_NONE    = 2'd0,
    MODE_SEXT16  = 2'd1,
    MODE_ZEXT16  = 2'd2,
    MODE_SPECIAL = 2'd3
  } mode_e;

  logic                  s1_valid_q;
  cls_e                  s1_cls_q;
  cls_e                  s1_cls_d;
  logic [25:0]           s1_field_q;

  logic                  s2_valid_q;
  logic [DATA_WIDTH-1:0] s2_imm_q;
  logic [DATA_WIDTH-1:0] s2_imm_d;
  mode_e                 s2_mode_q;
  mode_e                 s2_mode_d;
  logic                  s2_jump_q;
  logic                  s2_jump_d;

  logic                  s2_adv;
  logic                  s1_adv;
  logic [5:0]            opcode;

  assign s2_adv       = !s2_valid_q | bus.out_ready;
  assign s1_adv       = !s1_valid_q | s2_adv;
  assign bus.in_ready = s1_adv & !bus.flush;
  assign opcode       = bus.in_instr[31:26];

  always_comb begin
    s1_cls_d = CLS_SEXT16;
    case (opcode)
      6'h00, 6'h01:                      s1_cls_d = CLS_NONE;
      6'h02, 6'h03:                      s1_cls_d = CLS_J26;
      6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E: s1_cls_d = CLS_ZEXT16;
      6'h0F:                             s1_cls_d = CLS_LHI;
      default:                           s1_cls_d = CLS_SEXT16;
    endcase
  end

  // Flush outranks advance; with flush low, s1_adv equals in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cls_q   <= CLS_NONE;
      s1_field_q <= '0;
    end else if (bus.flush) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_cls_q   <= s1_cls_d;
        s1_field_q <= bus.in_instr[25:0];
      end
    end
  end

  always_comb begin
    s2_imm_d  = '0;
    s2_mode_d = MODE_NONE;
    s2_jump_d = 1'b0;
    case (s1_cls_q)
      CLS_SEXT16: begin
        s2_imm_d  = {{(DATA_WIDTH-16){s1_field_q[15]}}, s1_field_q[15:0]};
        s2_mode_d = MODE_SEXT16;
      end
      CLS_ZEXT16: begin
        s2_imm_d[15:0] = s1_field_q[15:0];
        s2_mode_d      = MODE_ZEXT16;
      end
      CLS_LHI: begin
        s2_imm_d[31:16] = s1_field_q[15:0];
        s2_mode_d       = MODE_SPECIAL;
      end
      CLS_J26: begin
        s2_imm_d  = {{(DATA_WIDTH-26){s1_field_q[25]}}, s1_field_q};
        s2_mode_d = MODE_SPECIAL;
        s2_jump_d = 1'b1;
      end
      default: begin
        s2_imm_d  = '0;
        s2_mode_d = MODE_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_imm_q   <= '0;
      s2_mode_q  <= MODE_NONE;
      s2_jump_q  <= 1'b0;
    end else if (bus.flush) begin
      s2_valid_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_imm_q  <= s2_imm_d;
        s2_mode_q <= s2_mode_d;
        s2_jump_q <= s2_jump_d;
      end
    end
  end

  assign bus.out_valid   = s2_valid_q;
  assign bus.out_imm     = s2_imm_q;
  assign bus.out_mode    = s2_mode_q;
  assign bus.out_is_jump = s2_jump_q;

`ifdef IMM_STATS_EN
  logic [15:0] neg_cnt_q;
  logic        neg_xfer;

  assign neg_xfer = s2_valid_q & bus.out_ready & s2_imm_q[DATA_WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_cnt_q <= '0;
    end else if (stat_clr) begin
      neg_cnt_q <= '0;
    end else if (neg_xfer && (neg_cnt_q != '1)) begin
      neg_cnt_q <= neg_cnt_q + 16'd1;
    end
  end

  assign stat_neg_cnt = neg_cnt_q;
`endif

endmodule
